// File: rtl/anycore_l15_reqdecoder.sv
// anycore_l15_reqdecoder: buffers AnyCore I-fetch/load/store pulses and issues them one at a time to the L1.5.
// Store has priority over load, and load has priority over I-fetch. Each source holds one pending request.
module anycore_l15_reqdecoder #(
    parameter int PADDR_W = 40,
    parameter int IC_OFF  = 5,
    parameter int DC_OFF  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               anycore_ic2mem_reqvalid,
    input  logic [PADDR_W-1:0] anycore_ic2mem_reqaddr,
    input  logic               anycore_dc2mem_ldvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_ldaddr,
    input  logic               anycore_dc2mem_stvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_staddr,
    input  logic [63:0]        anycore_dc2mem_stdata,
    input  logic [1:0]         anycore_dc2mem_stsize,
    output logic               transducer_l15_val,
    output logic [4:0]         transducer_l15_rqtype,
    output logic [PADDR_W-1:0] transducer_l15_address,
    output logic [2:0]         transducer_l15_size,
    output logic               transducer_l15_nc,
    output logic [63:0]        transducer_l15_data,
    input  logic               l15_transducer_ack,
    output logic               drop_err
);
    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic [1:0] {SEL_IC, SEL_LD, SEL_ST} sel_t;

    state_t state_q, state_d;
    sel_t sel_q, sel_n;
    logic ic_v_q, ic_v_d, ld_v_q, ld_v_d, st_v_q, st_v_d, drop_q, drop_d;
    logic [PADDR_W-1:0] ic_addr_q, ic_addr_d, ld_addr_q, ld_addr_d, st_addr_q, st_addr_d;
    logic [63:0] st_data_q, st_data_d, st_rev;
    logic [1:0] st_size_q, st_size_d;
    logic rel_ic, rel_ld, rel_st, any_v, load;
    logic [4:0] rqtype_q, rqtype_n;
    logic [PADDR_W-1:0] addr_q, addr_n;
    logic [2:0] size_q, size_n;
    logic [63:0] data_q, data_n;

    always_comb begin
        rel_ic = state_q == ISSUE && l15_transducer_ack && sel_q == SEL_IC;
        rel_ld = state_q == ISSUE && l15_transducer_ack && sel_q == SEL_LD;
        rel_st = state_q == ISSUE && l15_transducer_ack && sel_q == SEL_ST;
        // A pulse is taken only when its slot is empty or frees up on this same edge.
        ic_v_d = (ic_v_q && !rel_ic) || anycore_ic2mem_reqvalid;
        ld_v_d = (ld_v_q && !rel_ld) || anycore_dc2mem_ldvalid;
        st_v_d = (st_v_q && !rel_st) || anycore_dc2mem_stvalid;
        ic_addr_d = anycore_ic2mem_reqvalid && (!ic_v_q || rel_ic) ? anycore_ic2mem_reqaddr : ic_addr_q;
        ld_addr_d = anycore_dc2mem_ldvalid && (!ld_v_q || rel_ld) ? anycore_dc2mem_ldaddr : ld_addr_q;
        st_addr_d = anycore_dc2mem_stvalid && (!st_v_q || rel_st) ? anycore_dc2mem_staddr : st_addr_q;
        st_data_d = anycore_dc2mem_stvalid && (!st_v_q || rel_st) ? anycore_dc2mem_stdata : st_data_q;
        st_size_d = anycore_dc2mem_stvalid && (!st_v_q || rel_st) ? anycore_dc2mem_stsize : st_size_q;
        drop_d = drop_q || (anycore_ic2mem_reqvalid && ic_v_q && !rel_ic)
                        || (anycore_dc2mem_ldvalid && ld_v_q && !rel_ld)
                        || (anycore_dc2mem_stvalid && st_v_q && !rel_st);
        any_v = ic_v_q || ld_v_q || st_v_q;
        load = state_q == IDLE && any_v;
        state_d = state_q == IDLE ? (any_v ? ISSUE : IDLE) : (l15_transducer_ack ? IDLE : ISSUE);
        sel_n = st_v_q ? SEL_ST : ld_v_q ? SEL_LD : SEL_IC;
        st_rev = '0;
        for (int b = 0; b < 8; b++) st_rev[8*b +: 8] = st_data_q[56-8*b +: 8];
        rqtype_n = sel_n == SEL_ST ? 5'b00001 : sel_n == SEL_LD ? 5'b00000 : 5'b10000;
        addr_n = sel_n == SEL_ST ? st_addr_q
               : sel_n == SEL_LD ? ld_addr_q & ({PADDR_W{1'b1}} << DC_OFF)
               : ic_addr_q & ({PADDR_W{1'b1}} << IC_OFF);
        size_n = sel_n == SEL_ST ? {1'b0, st_size_q} + 3'd1 : sel_n == SEL_LD ? 3'b101 : 3'b110;
        data_n = sel_n == SEL_ST ? st_rev : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= SEL_IC;
            ic_v_q    <= 1'b0;
            ld_v_q    <= 1'b0;
            st_v_q    <= 1'b0;
            drop_q    <= 1'b0;
            ic_addr_q <= '0;
            ld_addr_q <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
            st_size_q <= '0;
            rqtype_q  <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ic_v_q    <= ic_v_d;
            ld_v_q    <= ld_v_d;
            st_v_q    <= st_v_d;
            drop_q    <= drop_d;
            ic_addr_q <= ic_addr_d;
            ld_addr_q <= ld_addr_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            st_size_q <= st_size_d;
            if (load) begin
                sel_q    <= sel_n;
                rqtype_q <= rqtype_n;
                addr_q   <= addr_n;
                size_q   <= size_n;
                data_q   <= data_n;
            end
        end
    end

    assign transducer_l15_val     = state_q == ISSUE;
    assign transducer_l15_rqtype  = rqtype_q;
    assign transducer_l15_address = addr_q;
    assign transducer_l15_size    = size_q;
    assign transducer_l15_nc      = addr_q[PADDR_W-1];
    assign transducer_l15_data    = data_q;
    assign drop_err               = drop_q;
endmodule

// File: tb/tb_anycore_l15_reqdecoder.sv
// tb_anycore_l15_reqdecoder: directed scenarios plus randomized traffic against a request-level reference model.
module tb_anycore_l15_reqdecoder;
    localparam int PW = 40;
    localparam int ICO = 5;
    localparam int DCO = 4;

    logic clk = 0, rst_n = 0;
    logic ic_v = 0, ld_v = 0, st_v = 0, ack = 0;
    logic [PW-1:0] ic_a = '0, ld_a = '0, st_a = '0;
    logic [63:0] st_d = '0;
    logic [1:0] st_sz = '0;
    logic val, nc, drop;
    logic [4:0] rqtype;
    logic [PW-1:0] addr;
    logic [2:0] size;
    logic [63:0] data;
    int errors = 0, checks = 0;

    anycore_l15_reqdecoder #(.PADDR_W(PW), .IC_OFF(ICO), .DC_OFF(DCO)) dut (
        .clk(clk), .rst_n(rst_n),
        .anycore_ic2mem_reqvalid(ic_v), .anycore_ic2mem_reqaddr(ic_a),
        .anycore_dc2mem_ldvalid(ld_v), .anycore_dc2mem_ldaddr(ld_a),
        .anycore_dc2mem_stvalid(st_v), .anycore_dc2mem_staddr(st_a),
        .anycore_dc2mem_stdata(st_d), .anycore_dc2mem_stsize(st_sz),
        .transducer_l15_val(val), .transducer_l15_rqtype(rqtype),
        .transducer_l15_address(addr), .transducer_l15_size(size),
        .transducer_l15_nc(nc), .transducer_l15_data(data),
        .l15_transducer_ack(ack), .drop_err(drop)
    );

    always #5 clk = ~clk;

    // Reference model: pending request per source (0=IC, 1=LD, 2=ST) and the request on the bus.
    logic m_v[3] = '{default: 1'b0};
    logic [PW-1:0] m_a[3] = '{default: '0};
    logic [63:0] m_d = '0;
    logic [1:0] m_sz = '0;
    logic e_val = 0, e_drop = 0;
    int e_src = 0;
    logic [4:0] e_type = '0;
    logic [PW-1:0] e_addr = '0;
    logic [2:0] e_size = '0;
    logic [63:0] e_data = '0;

    function automatic logic [63:0] rev64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        int rel;
        logic p[3];
        logic [PW-1:0] a[3];
        if (!rst_n) begin
            m_v = '{default: 1'b0};
            e_val = 0;
            e_drop = 0;
            return;
        end
        p = '{ic_v, ld_v, st_v};
        a = '{ic_a, ld_a, st_a};
        rel = (e_val && ack) ? e_src : -1;
        if (e_val) e_val = !ack;
        else if (m_v[0] || m_v[1] || m_v[2]) begin
            e_src = m_v[2] ? 2 : m_v[1] ? 1 : 0;
            e_val = 1;
            e_type = e_src == 2 ? 5'd1 : e_src == 1 ? 5'd0 : 5'd16;
            e_addr = e_src == 2 ? m_a[2] : e_src == 1 ? (m_a[1] >> DCO) << DCO : (m_a[0] >> ICO) << ICO;
            e_size = e_src == 2 ? {1'b0, m_sz} + 3'd1 : e_src == 1 ? 3'd5 : 3'd6;
            e_data = e_src == 2 ? rev64(m_d) : 64'd0;
        end
        for (int k = 0; k < 3; k++) begin
            if (p[k] && (!m_v[k] || rel == k)) begin
                m_v[k] = 1;
                m_a[k] = a[k];
                if (k == 2) begin
                    m_d = st_d;
                    m_sz = st_sz;
                end
            end else if (p[k]) e_drop = 1;
            else if (rel == k) m_v[k] = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("val", val, e_val);
        chk("drop_err", drop, e_drop);
        if (e_val) begin
            chk("rqtype", rqtype, e_type);
            chk("address", addr, e_addr);
            chk("size", size, e_size);
            chk("nc", nc, e_addr[PW-1]);
            chk("data", data, e_data);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] order[$];
        step();
        step();
        chk("reset_val", val, 0);
        chk("reset_fields", {rqtype, size, nc}, 0);
        chk("reset_addr", addr, 0);
        chk("reset_data", data, 0);
        chk("reset_drop", drop, 0);
        rst_n = 1;
        step();
        // I-fetch with ack held high
        ack = 1;
        ic_v = 1;
        ic_a = 40'h00_8000_1234;
        step();
        ic_v = 0;
        step();
        chk("ic_val", val, 1);
        chk("ic_rqtype", rqtype, 5'b10000);
        chk("ic_addr", addr, 40'h00_8000_1220);
        chk("ic_size", size, 3'b110);
        chk("ic_nc", nc, 0);
        step();
        chk("ic_val_one_cycle", val, 0);
        // store with ack arriving in the third issue cycle
        ack = 0;
        st_v = 1;
        st_a = 40'h80_0000_0008;
        st_sz = 3;
        st_d = 64'h0011223344556677;
        step();
        st_v = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_val_held", val, 1);
            chk("st_data", data, 64'h7766554433221100);
            chk("st_size", size, 3'b100);
            chk("st_nc", nc, 1);
        end
        ack = 1;
        step();
        chk("st_val_after_ack", val, 0);
        // simultaneous pulses on all sources
        ic_v = 1;
        ld_v = 1;
        st_v = 1;
        ic_a = 40'h00_0000_1000;
        ld_a = 40'h00_0000_2000;
        st_a = 40'h00_0000_3000;
        step();
        ic_v = 0;
        ld_v = 0;
        st_v = 0;
        for (int i = 0; i < 8; i++) begin
            if (val) order.push_back(rqtype);
            step();
        end
        chk("simul_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("simul_first_st", order[0], 5'b00001);
            chk("simul_second_ld", order[1], 5'b00000);
            chk("simul_third_ic", order[2], 5'b10000);
        end
        chk("simul_no_drop", drop, 0);
        // lost LD pulse, then LD pulse in its own ack cycle
        ack = 0;
        ld_v = 1;
        ld_a = 40'h12_3456_789A;
        step();
        ld_v = 0;
        step();
        chk("ld_pending_val", val, 1);
        ld_v = 1;
        ld_a = 40'h00_0000_5555;
        step();
        chk("ld_drop", drop, 1);
        chk("ld_addr_kept", addr, 40'h12_3456_7890);
        ld_a = 40'h00_0000_ABCF;
        ack = 1;
        step();
        ld_v = 0;
        ack = 0;
        chk("ld_gap", val, 0);
        step();
        chk("ld_ack_cycle_val", val, 1);
        chk("ld_ack_cycle_addr", addr, 40'h00_0000_ABC0);
        chk("ld_ack_cycle_size", size, 3'b101);
        ack = 1;
        step();
        // reset in the middle of an issue
        ack = 0;
        ic_v = 1;
        ic_a = 40'h00_0000_0040;
        step();
        ic_v = 0;
        step();
        chk("rst_pre_val", val, 1);
        rst_n = 0;
        step();
        chk("rst_mid_val", val, 0);
        chk("rst_mid_fields", {rqtype, size, nc}, 0);
        chk("rst_mid_addr", addr, 0);
        chk("rst_mid_drop", drop, 0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_reissue", val, 0);
        end
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            ic_v = $urandom_range(0, 3) == 0;
            ld_v = $urandom_range(0, 3) == 0;
            st_v = $urandom_range(0, 3) == 0;
            ic_a = PW'({$urandom(), $urandom()});
            ld_a = PW'({$urandom(), $urandom()});
            st_a = PW'({$urandom(), $urandom()});
            st_d = {$urandom(), $urandom()};
            st_sz = 2'($urandom_range(0, 3));
            ack = $urandom_range(0, 1) == 1;
            rst_n = $urandom_range(0, 199) != 0;
            step();
        end
        ic_v = 0;
        ld_v = 0;
        st_v = 0;
        rst_n = 1;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/anycore_l15_reqdecoder.md
ANYCORE_L15_REQDECODER -- requirements
Module: anycore_l15_reqdecoder

Interface
REQ-001 SHALL have parameter PADDR_W, default 40, physical address width.
REQ-002 SHALL have parameter IC_OFF, default 5, log2 of the I-cache line size in bytes.
REQ-003 SHALL have parameter DC_OFF, default 4, log2 of the D-cache line size in bytes.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port anycore_ic2mem_reqvalid, input, 1, one-cycle I-fetch miss pulse.
REQ-007 SHALL have port anycore_ic2mem_reqaddr, input, PADDR_W, I-fetch miss address.
REQ-008 SHALL have port anycore_dc2mem_ldvalid, input, 1, one-cycle load miss pulse.
REQ-009 SHALL have port anycore_dc2mem_ldaddr, input, PADDR_W, load miss address.
REQ-010 SHALL have port anycore_dc2mem_stvalid, input, 1, one-cycle store pulse.
REQ-011 SHALL have port anycore_dc2mem_staddr, input, PADDR_W, store address.
REQ-012 SHALL have port anycore_dc2mem_stdata, input, 64, store data, little-endian.
REQ-013 SHALL have port anycore_dc2mem_stsize, input, 2, store size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-014 SHALL have port transducer_l15_val, output, 1, request valid.
REQ-015 SHALL have port transducer_l15_rqtype, output, 5, request type: LOAD_RQ=00000, STORE_RQ=00001, IMISS_RQ=10000.
REQ-016 SHALL have port transducer_l15_address, output, PADDR_W, request address.
REQ-017 SHALL have port transducer_l15_size, output, 3, size code: 1B=001, 2B=010, 4B=011, 8B=100, 16B=101, 32B=110.
REQ-018 SHALL have port transducer_l15_nc, output, 1, noncacheable flag.
REQ-019 SHALL have port transducer_l15_data, output, 64, store data, big-endian.
REQ-020 SHALL have port l15_transducer_ack, input, 1, request accepted.
REQ-021 SHALL have port drop_err, output, 1, sticky flag set when a request pulse was lost.

Function
REQ-022 SHALL hold three one-entry buffers (IC, LD, ST), each a valid bit plus its captured fields.
REQ-023 SHALL capture a pulse into its buffer at the clock edge when that buffer is empty or is being released in the same cycle; simultaneous pulses on all three sources SHALL all be captured.
REQ-024 SHALL ignore a pulse arriving at an occupied, non-releasing buffer, leaving the buffer unchanged, and SHALL set drop_err on the next edge.
REQ-025 SHALL implement FSM IDLE/ISSUE: in IDLE with any buffer valid, select fixed priority ST > LD > IC, register output fields, and enter ISSUE.
REQ-026 SHALL assert transducer_l15_val exactly while in ISSUE, with all output fields stable.
REQ-027 SHALL, in ISSUE with l15_transducer_ack=1, clear the selected buffer and return to IDLE; the minimum spacing between request starts is 2 cycles.
REQ-028 SHALL form IC requests as IMISS_RQ with the address low IC_OFF bits zeroed and size 110.
REQ-029 SHALL form LD requests as LOAD_RQ with the address low DC_OFF bits zeroed and size 101.
REQ-030 SHALL form ST requests as STORE_RQ with the unmodified address and size = stsize+1.
REQ-031 SHALL drive transducer_l15_data as the byte-reversed store data (byte0 to bits 63:56) for ST requests and as 0 for other types.
REQ-032 SHALL drive transducer_l15_nc = address[PADDR_W-1] for all request types.
REQ-033 SHALL ignore l15_transducer_ack while in IDLE.

Reset
REQ-034 SHALL, when rst_n=0 at a clock edge (including mid-ISSUE), clear all buffers, enter IDLE, and drive val=0, drop_err=0, and rqtype, address, size, nc and data to 0.

Verification
REQ-035 SHALL cover: IC pulse with addr 0x00_8000_1234, ack held 1 -> val asserted for 1 cycle with rqtype 10000, address 0x00_8000_1220, size 110, nc 0.
REQ-036 SHALL cover: ST pulse with addr 0x80_0000_0008, stsize 3, data 0x0011223344556677, ack delayed 3 cycles -> val held 3 cycles with data 0x7766554433221100, size 100, nc 1.
REQ-037 SHALL cover: IC, LD and ST pulsed in the same cycle -> issue order ST, LD, IC with drop_err remaining 0.
REQ-038 SHALL cover: second LD pulse while LD is pending without ack -> second pulse lost and drop_err=1; LD pulse in its own ack cycle -> accepted.
REQ-039 SHALL cover: rst_n=0 during ISSUE -> val=0 on the next cycle, no request issued after release until a new pulse arrives.
